// File: rtl/input_buffer.sv
// Viterbi decoder front-end buffer: holds the word being decoded as eight 2-bit symbol pairs
// and queues words that arrive meanwhile in a small circular FIFO.
module input_buffer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        renew,
  input  logic [15:0] data_in,
  output logic [1:0]  bit_pair_0,
  output logic [1:0]  bit_pair_1,
  output logic [1:0]  bit_pair_2,
  output logic [1:0]  bit_pair_3,
  output logic [1:0]  bit_pair_4,
  output logic [1:0]  bit_pair_5,
  output logic [1:0]  bit_pair_6,
  output logic [1:0]  bit_pair_7
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

  logic [15:0]     active_q, active_d;
  logic            valid_q, valid_d;
  logic [15:0]     last_q;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic new_word, fifo_empty, fifo_full, take, pop, load_direct, push;

  // A word is accepted on its first cycle only; a held value or all-zero word is ignored.
  always_comb begin
    new_word    = (data_in != 16'h0000) && (data_in != last_q);
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CntFull);
    take        = !valid_q || renew;
    pop         = take && !fifo_empty;
    load_direct = take && fifo_empty && new_word;
    // Pop in the same cycle frees a slot, so a full FIFO can still accept.
    push        = new_word && !load_direct && (!fifo_full || pop);
  end

  always_comb begin
    active_d = active_q;
    valid_d  = valid_q;
    if (pop) begin
      active_d = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
    end else if (load_direct) begin
      active_d = data_in;
      valid_d  = 1'b1;
    end else if (valid_q && renew) begin
      valid_d  = 1'b0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      active_q <= active_d;
      valid_q  <= valid_d;
      last_q   <= data_in;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign bit_pair_0 = active_q[1:0];
  assign bit_pair_1 = active_q[3:2];
  assign bit_pair_2 = active_q[5:4];
  assign bit_pair_3 = active_q[7:6];
  assign bit_pair_4 = active_q[9:8];
  assign bit_pair_5 = active_q[11:10];
  assign bit_pair_6 = active_q[13:12];
  assign bit_pair_7 = active_q[15:14];

endmodule

// File: tb/tb_input_buffer.sv
// Scoreboard bench for input_buffer: a queue-based word model predicts the active word each
// cycle; a monitor compares the DUT symbol pairs after every rising edge.
module tb_input_buffer;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        renew = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [1:0]  bp0, bp1, bp2, bp3, bp4, bp5, bp6, bp7;
  logic [15:0] dut_word;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q [$];

  // Reference model state
  logic [15:0] m_pending [$];
  logic [15:0] m_active = 16'h0000;
  bit          m_valid  = 1'b0;
  logic [15:0] m_last   = 16'h0000;

  input_buffer #(.FIFO_DEPTH(Depth)) dut (
    .clk        (clk),
    .rst        (rst),
    .renew      (renew),
    .data_in    (data_in),
    .bit_pair_0 (bp0),
    .bit_pair_1 (bp1),
    .bit_pair_2 (bp2),
    .bit_pair_3 (bp3),
    .bit_pair_4 (bp4),
    .bit_pair_5 (bp5),
    .bit_pair_6 (bp6),
    .bit_pair_7 (bp7)
  );

  assign dut_word = {bp7, bp6, bp5, bp4, bp3, bp2, bp1, bp0};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: pairs7..0 word %h, expected %h", name, $time, got, want);
    end
  endtask

  // One clock of stimulus; the model predicts the word visible after the coming edge.
  task automatic step(input bit r, input bit ren, input logic [15:0] d);
    bit accept;
    @(negedge clk);
    rst     = r;
    renew   = ren;
    data_in = d;
    if (r) begin
      #1;
      check("reset_async", dut_word, 16'h0000);
      m_pending.delete();
      m_active = 16'h0000;
      m_valid  = 1'b0;
      m_last   = 16'h0000;
    end else begin
      accept = (d != 16'h0000) && (d != m_last);
      m_last = d;
      if (!m_valid || ren) begin
        if (m_pending.size() > 0) begin
          m_active = m_pending.pop_front();
          m_valid  = 1'b1;
          if (accept) m_pending.push_back(d);
        end else if (accept) begin
          m_active = d;
          m_valid  = 1'b1;
        end else if (m_valid) begin
          m_valid = 1'b0;
        end
      end else if (accept && m_pending.size() < Depth) begin
        m_pending.push_back(d);
      end
    end
    exp_q.push_back(m_active);
  endtask

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("active_word", dut_word, e);
      end
    end
  end

  initial begin : stimulus
    logic [15:0] d;
    logic [15:0] pool [6];
    pool[0] = 16'h0000; pool[1] = 16'hA5A5; pool[2] = 16'h5A5A;
    pool[3] = 16'hFFFF; pool[4] = 16'h1234; pool[5] = 16'h0001;

    // Reset with idle input, then zeros must never load
    step(1, 0, 16'h0000);
    step(1, 0, 16'h0000);
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);
    // Single-cycle word loads straight into active, then a held word queues once
    step(0, 0, 16'hA5A5);
    step(0, 0, 16'h5A5A);
    step(0, 0, 16'h5A5A);
    step(0, 0, 16'h0000);
    step(0, 1, 16'h0000);
    step(0, 0, 16'h0000);
    step(0, 1, 16'h0000);
    step(0, 0, 16'h0000);
    // Fill FIFO while busy, one more is dropped, then drain in order
    step(0, 0, 16'h0011);
    step(0, 0, 16'h1111);
    step(0, 0, 16'h2222);
    step(0, 0, 16'h3333);
    step(0, 0, 16'h4444);
    step(0, 0, 16'h5555);
    step(0, 0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 16'h0000);
      step(0, 0, 16'h0000);
    end
    // Renew with FIFO full plus a new word in the same cycle
    step(0, 0, 16'h0F0F);
    step(0, 0, 16'h1010);
    step(0, 0, 16'h2020);
    step(0, 0, 16'h3030);
    step(0, 0, 16'h4040);
    step(0, 1, 16'hAAAA);
    step(0, 0, 16'h0000);
    for (int i = 0; i < 6; i++) step(0, 1, 16'h0000);
    // Reset mid-stream with FIFO non-empty, then renew must show nothing stale
    step(0, 0, 16'hFFFF);
    step(0, 0, 16'h0102);
    step(0, 0, 16'h0304);
    step(1, 0, 16'h0000);
    step(0, 0, 16'h0000);
    step(0, 1, 16'h0000);
    step(0, 1, 16'h0000);

    // Randomized traffic
    d = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 5) == 5) d = 16'($urandom);
        else d = pool[$urandom_range(0, 5)];
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), d);
    end
    step(0, 0, 16'h0000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected words never compared, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
